// File: rtl/demorgan_sweep_ctrl_if.sv
// demorgan_sweep_ctrl_if: sweep control, network compare inputs and result outputs
interface demorgan_sweep_ctrl_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic            abort;
    logic            lhs_in;
    logic            rhs_in;
    logic [N_IN-1:0] vec_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   mismatch_count;
    logic [N_IN-1:0] first_fail_vec;
    logic            first_fail_valid;

    modport master (
        output start, abort, lhs_in, rhs_in,
        input  vec_out, busy, done, pass, mismatch_count, first_fail_vec, first_fail_valid
    );

    modport slave (
        input  start, abort, lhs_in, rhs_in,
        output vec_out, busy, done, pass, mismatch_count, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/demorgan_sweep_ctrl.sv
// demorgan_sweep_ctrl: sweeps a shared vector through two networks and checks they agree
module demorgan_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input logic                  clk,
    input logic                  reset,
    demorgan_sweep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    localparam logic [N_IN-1:0] VEC_LAST    = '1;
    localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE - 1);

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d, ffv_q, ffv_d;
    logic [N_IN:0]   cnt_q, cnt_d;
    logic [7:0]      settle_q, settle_d;
    logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d, ffval_q, ffval_d;
    logic            mis;

    // X/Z on either network output is treated as a disagreement
    assign mis = (bus.lhs_in ^ bus.rhs_in) !== 1'b0;

    // state and datapath registers, asynchronously cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            vec_q    <= '0;
            ffv_q    <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            ffval_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            ffv_q    <= ffv_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            ffval_q  <= ffval_d;
        end
    end

    // next state; abort beats both settle countdown and compare
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = bus.start ? S_SETTLE : S_IDLE;
            S_SETTLE: state_d = bus.abort ? S_IDLE : (settle_q == 8'd0 ? S_CHECK : S_SETTLE);
            S_CHECK:  state_d = bus.abort ? S_IDLE : (vec_q == VEC_LAST ? S_DONE : S_SETTLE);
            default:  state_d = S_IDLE;
        endcase
    end

    // registered outputs and sweep bookkeeping
    always_comb begin
        vec_d    = vec_q;
        ffv_d    = ffv_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        ffval_d  = ffval_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cnt_d    = '0;
                    ffval_d  = 1'b0;
                    pass_d   = 1'b0;
                    vec_d    = '0;
                    settle_d = SETTLE_LOAD;
                    busy_d   = 1'b1;
                end
            end
            S_SETTLE, S_CHECK: begin
                if (bus.abort) begin
                    busy_d = 1'b0;
                    vec_d  = '0;
                    pass_d = 1'b0;
                end else if (state_q == S_SETTLE) begin
                    if (settle_q != 8'd0) settle_d = settle_q - 8'd1;
                end else begin
                    cnt_d = cnt_q + {{N_IN{1'b0}}, mis};
                    if (mis && !ffval_q) begin
                        ffv_d   = vec_q;
                        ffval_d = 1'b1;
                    end
                    if (vec_q == VEC_LAST) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        pass_d = (cnt_d == '0);
                    end else begin
                        vec_d    = vec_q + 1'b1;
                        settle_d = SETTLE_LOAD;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.vec_out          = vec_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.mismatch_count   = cnt_q;
    assign bus.first_fail_vec   = ffv_q;
    assign bus.first_fail_valid = ffval_q;
endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// tb_demorgan_sweep_ctrl: table-driven sweeps with a result scoreboard plus abort/reset sequences
module tb_demorgan_sweep_ctrl;
    typedef struct {
        logic       pass;
        logic [2:0] cnt;
        logic [1:0] ffv;
        logic       ffval;
    } exp_t;

    typedef struct {
        int   s;
        int   mode;
        int   pulse;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    int   sel = 0;
    int   mode = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t tbl[6];

    logic [1:0] vec_m, ffv_m;
    logic [2:0] cnt_m;
    logic       busy_m, done_m, pass_m, ffval_m;

    demorgan_sweep_ctrl_if #(.N_IN(2)) b0();
    demorgan_sweep_ctrl_if #(.N_IN(2)) b1();

    demorgan_sweep_ctrl #(.N_IN(2), .SETTLE(1)) u0 (.clk(clk), .reset(reset), .bus(b0));
    demorgan_sweep_ctrl #(.N_IN(2), .SETTLE(3)) u1 (.clk(clk), .reset(reset), .bus(b1));

    always #5 clk = ~clk;

    // network B model: the correct ~(A|B), optionally corrupted on chosen vectors
    function automatic logic rhs_f(input logic [1:0] v, input int md);
        logic good;
        good = ~(v[1] | v[0]);
        case (md)
            1: return good ^ (v == 2'b10);
            2: return ~good;
            3: return good ^ v[0];
            4: return good ^ (v == 2'b01);
            default: return good;
        endcase
    endfunction

    assign b0.start  = start & (sel == 0);
    assign b1.start  = start & (sel != 0);
    assign b0.abort  = abort & (sel == 0);
    assign b1.abort  = abort & (sel != 0);
    assign b0.lhs_in = ~b0.vec_out[1] & ~b0.vec_out[0];
    assign b1.lhs_in = ~b1.vec_out[1] & ~b1.vec_out[0];
    assign b0.rhs_in = rhs_f(b0.vec_out, mode);
    assign b1.rhs_in = rhs_f(b1.vec_out, mode);

    assign vec_m   = (sel != 0) ? b1.vec_out          : b0.vec_out;
    assign ffv_m   = (sel != 0) ? b1.first_fail_vec   : b0.first_fail_vec;
    assign cnt_m   = (sel != 0) ? b1.mismatch_count   : b0.mismatch_count;
    assign busy_m  = (sel != 0) ? b1.busy             : b0.busy;
    assign done_m  = (sel != 0) ? b1.done             : b0.done;
    assign pass_m  = (sel != 0) ? b1.pass             : b0.pass;
    assign ffval_m = (sel != 0) ? b1.first_fail_valid : b0.first_fail_valid;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // one full sweep on the selected instance; optional start pulse while busy
    task automatic run_sweep(input int s, input int md, input int pulse_at, input exp_t e);
        int   per;
        int   k;
        int   vec_bad;
        exp_t x;
        sel = s;
        mode = md;
        per = (s == 0) ? 2 : 4;
        sb.push_back(e);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy_m), 1);
        k = 0;
        vec_bad = 0;
        while (k < 4 * per + 4) begin
            if (done_m) break;
            if (k < 4 * per && int'(vec_m) != k / per) vec_bad++;
            if (k == pulse_at - 1) start = 1'b1;
            if (k == pulse_at) start = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        chk("done_edge", done_m ? k : -1, 4 * per);
        chk("vec_seq_errs", vec_bad, 0);
        x = sb.pop_front();
        if (done_m) begin
            chk("pass", int'(pass_m), int'(x.pass));
            chk("mismatch_count", int'(cnt_m), int'(x.cnt));
            chk("first_fail_valid", int'(ffval_m), int'(x.ffval));
            if (x.ffval) chk("first_fail_vec", int'(ffv_m), int'(x.ffv));
            chk("busy_at_done", int'(busy_m), 0);
            @(posedge clk); #1;
            chk("done_one_cycle", int'(done_m), 0);
            chk("pass_held", int'(pass_m), int'(x.pass));
        end
    endtask

    initial begin
        int quiet;
        tbl[0] = '{0, 0, -1, '{1'b1, 3'd0, 2'd0, 1'b0}};
        tbl[1] = '{0, 1, -1, '{1'b0, 3'd1, 2'd2, 1'b1}};
        tbl[2] = '{0, 2, -1, '{1'b0, 3'd4, 2'd0, 1'b1}};
        tbl[3] = '{0, 3, -1, '{1'b0, 3'd2, 2'd1, 1'b1}};
        tbl[4] = '{1, 0,  5, '{1'b1, 3'd0, 2'd0, 1'b0}};
        tbl[5] = '{1, 2, -1, '{1'b0, 3'd4, 2'd0, 1'b1}};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_vec", int'(b0.vec_out), 0);
        chk("rst_busy", int'(b0.busy), 0);
        chk("rst_done", int'(b0.done), 0);
        chk("rst_pass", int'(b0.pass), 0);
        chk("rst_cnt", int'(b0.mismatch_count), 0);
        chk("rst_ffv", int'(b0.first_fail_vec), 0);
        chk("rst_ffval", int'(b0.first_fail_valid), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_sweep(tbl[i].s, tbl[i].mode, tbl[i].pulse, tbl[i].e);

        // abort during CHECK of vector 01 while it mismatches
        sel = 0;
        mode = 4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_pre_vec", int'(vec_m), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", int'(busy_m), 0);
        chk("abort_vec", int'(vec_m), 0);
        chk("abort_cnt", int'(cnt_m), 0);
        chk("abort_ffval", int'(ffval_m), 0);
        chk("abort_pass", int'(pass_m), 0);
        quiet = 0;
        for (int i = 0; i < 4; i++) begin
            quiet += int'(done_m);
            @(posedge clk); #1;
        end
        chk("abort_no_done", quiet, 0);
        run_sweep(0, 4, -1, '{1'b0, 3'd1, 2'd1, 1'b1});

        // asynchronous reset mid-SETTLE with nonzero progress
        sel = 0;
        mode = 2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_cnt", int'(cnt_m), 2);
        #3 reset = 1'b1;
        #1;
        chk("arst_vec", int'(vec_m), 0);
        chk("arst_busy", int'(busy_m), 0);
        chk("arst_cnt", int'(cnt_m), 0);
        chk("arst_ffval", int'(ffval_m), 0);
        chk("arst_done", int'(done_m), 0);
        chk("arst_pass", int'(pass_m), 0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        run_sweep(0, 0, -1, '{1'b1, 3'd0, 2'd0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
